// File: rtl/html_source_reader_pkg.sv
// Shared character constants, FSM encoding and whitespace helper for the html source reader.
// The `CHAR_* macros carry the project-wide character definitions into typed package constants.
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif
`ifndef CHAR_NUL
`define CHAR_NUL 'h00
`endif
`ifndef CHAR_SPACE
`define CHAR_SPACE 'h20
`endif
`ifndef CHAR_CR
`define CHAR_CR 'h0D
`endif
`ifndef CHAR_LF
`define CHAR_LF 'h0A
`endif
`ifndef CHAR_TAB
`define CHAR_TAB 'h09
`endif

package html_source_reader_pkg;

  localparam int CHAR_W = `CHAR_BITES;

  localparam logic [CHAR_W-1:0] CHAR_NUL   = CHAR_W'(`CHAR_NUL);
  localparam logic [CHAR_W-1:0] CHAR_SPACE = CHAR_W'(`CHAR_SPACE);
  localparam logic [CHAR_W-1:0] CHAR_CR    = CHAR_W'(`CHAR_CR);
  localparam logic [CHAR_W-1:0] CHAR_LF    = CHAR_W'(`CHAR_LF);
  localparam logic [CHAR_W-1:0] CHAR_TAB   = CHAR_W'(`CHAR_TAB);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_ws(input logic [CHAR_W-1:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF) || (c == CHAR_TAB);
  endfunction

endpackage

// File: rtl/char_normalizer.sv
// Maps CR, LF and TAB to space; every other code passes through untouched.
// Shared with the element parser for its own whitespace handling.
module char_normalizer
  import html_source_reader_pkg::*;
(
  input  logic [CHAR_W-1:0] i_char,
  output logic [CHAR_W-1:0] o_char
);

  always_comb begin
    o_char = i_char;
    if (is_ws(i_char)) o_char = CHAR_SPACE;
  end

endmodule

// File: rtl/html_source_reader.sv
// Streams the stored HTML document from a synchronous ROM into html_parser, one char per clock,
// holding the presented char while the parser pauses and flagging done at NUL or length limit.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | parser held disabled, waiting for start
//   ST_STREAM | presenting mem[addr]; each unpaused cycle accepts one char
//   ST_DONE   | document finished, char_count frozen, waiting for restart
module html_source_reader
  import html_source_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_LEN    = 4096
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  pause,
  input  logic [CHAR_W-1:0]     rom_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [CHAR_W-1:0]     char,
  output logic                  state_enable,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] char_count
);

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(MAX_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] C_SAT = '1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_count;

  logic w_streaming;
  logic w_is_nul;
  logic w_accept;
  logic w_nul_end;
  logic w_max_end;
  logic w_restart;

  assign w_streaming = (r_state == ST_STREAM);
  assign w_is_nul    = (rom_data == CHAR_NUL);
  // A paused NUL is not an end yet: the parser may still be finishing a draw.
  assign w_accept    = w_streaming & ~pause & ~w_is_nul;
  assign w_nul_end   = w_streaming & ~pause &  w_is_nul;
  assign w_max_end   = w_accept & (r_count == LAST);
  assign w_restart   = start & ~w_streaming;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_nul_end || w_max_end) w_state_nxt = ST_DONE;
      ST_DONE:   if (start) w_state_nxt = ST_STREAM;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= BASE;
      r_count <= '0;
    end else if (w_restart) begin
      r_addr  <= BASE;
      r_count <= '0;
    end else if (w_accept) begin
      r_addr  <= r_addr + 1'b1;
      r_count <= (r_count == C_SAT) ? r_count : r_count + 1'b1;
    end
  end

  // The NUL cycle already reports done and drops the enable, so the parser never consumes the NUL.
  always_comb begin
    rom_addr     = BASE;
    state_enable = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_STREAM: begin
        rom_addr     = (w_accept && !w_max_end) ? r_addr + 1'b1 : r_addr;
        state_enable = ~w_nul_end;
        done         = w_nul_end;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign char_count = r_count;

  char_normalizer u_char_normalizer (
    .i_char (rom_data),
    .o_char (char)
  );

endmodule
